// File: rtl/ct_pkg.sv
// Shared types and helpers for the control-transfer sequencer.
package ct_pkg;

  typedef enum logic [2:0] {
    OpGoto = 3'd0,
    OpLt   = 3'd1,
    OpGt   = 3'd2,
    OpEq   = 3'd3,
    OpGe   = 3'd4,
    OpLe   = 3'd5,
    OpCall = 3'd6,
    OpRet  = 3'd7
  } ct_op_t;

  typedef enum logic [2:0] {
    StIdle,
    StMemReq,
    StMemWait,
    StEval,
    StPop,
    StJmpNext
  } ct_state_t;

  // Caller sign-extends temp1 so the helper stays width-agnostic.
  function automatic logic cond_taken(ct_op_t op, longint temp1);
    logic taken;
    case (op)
      OpLt:    taken = temp1 < 0;
      OpGt:    taken = temp1 > 0;
      OpEq:    taken = temp1 == 0;
      OpGe:    taken = temp1 >= 0;
      OpLe:    taken = temp1 <= 0;
      default: taken = 1'b0;
    endcase
    return taken;
  endfunction

endpackage

// File: rtl/ctrl_transfer_unit_if.sv
// Request, program-memory and status signals between the main FSM and the sequencer.
interface ctrl_transfer_unit_if #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 8
) ();

  logic                start;
  ct_pkg::ct_op_t      op;
  logic [ADDR_W-1:0]   ip_in;
  logic [DATA_W-1:0]   temp1;
  logic                mem_rd;
  logic [ADDR_W-1:0]   mem_addr;
  logic [ADDR_W-1:0]   mem_q;
  logic [ADDR_W-1:0]   ip_out;
  logic                ip_load;
  logic                busy;
  logic                fault;
  logic                done;
  logic                empty;
  logic                full;

  modport master (
    output start, op, ip_in, temp1, mem_q,
    input  mem_rd, mem_addr, ip_out, ip_load, busy, fault, done, empty, full
  );

  modport slave (
    input  start, op, ip_in, temp1, mem_q,
    output mem_rd, mem_addr, ip_out, ip_load, busy, fault, done, empty, full
  );

endinterface

// File: rtl/return_stack.sv
// Register-array LIFO holding return addresses; empty/full are registered off the pointer.
module return_stack #(
  parameter int unsigned ADDR_W      = 8,
  parameter int unsigned STACK_DEPTH = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic              pop,
  input  logic [ADDR_W-1:0] din,
  output logic [ADDR_W-1:0] dout,
  output logic              empty,
  output logic              full
);

  localparam int unsigned IdxW = $clog2(STACK_DEPTH);
  localparam int unsigned PtrW = IdxW + 1;

  logic [ADDR_W-1:0] mem_q [STACK_DEPTH];
  logic [PtrW-1:0]   ptr_q, ptr_d;
  logic              empty_q, full_q;
  logic              do_push, do_pop;
  logic [IdxW-1:0]   top_idx;

  assign do_push = push && !full_q;
  assign do_pop  = pop && !empty_q;
  assign top_idx = ptr_q[IdxW-1:0] - IdxW'(1);
  assign dout    = mem_q[top_idx];
  assign empty   = empty_q;
  assign full    = full_q;

  always_comb begin
    ptr_d = ptr_q;
    if (do_push) begin
      ptr_d = ptr_q + PtrW'(1);
    end else if (do_pop) begin
      ptr_d = ptr_q - PtrW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q   <= '0;
      empty_q <= 1'b1;
      full_q  <= 1'b0;
    end else begin
      ptr_q   <= ptr_d;
      empty_q <= (ptr_d == '0);
      full_q  <= (ptr_d == PtrW'(STACK_DEPTH));
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[ptr_q[IdxW-1:0]] <= din;
    end
  end

endmodule

// File: rtl/ctrl_transfer_unit.sv
// Multi-cycle sequencer for GOTO/IF_xx/CALL/RET: fetches the target, evaluates the
// condition, maintains the return stack and hands back the next ip with a load strobe.
module ctrl_transfer_unit import ct_pkg::*; #(
  parameter int unsigned ADDR_W      = 8,
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned STACK_DEPTH = 8
) (
  input logic                 clk,
  input logic                 reset,
  ctrl_transfer_unit_if.slave bus
);

  ct_state_t         state_q, state_d;
  ct_op_t            op_q, op_d;
  logic [ADDR_W-1:0] ip_q, ip_d;
  logic [DATA_W-1:0] temp1_q, temp1_d;
  logic [ADDR_W-1:0] target_q, target_d;
  logic [ADDR_W-1:0] next_ip_q, next_ip_d;
  logic              fault_q, fault_d;

  logic              push, pop;
  logic [ADDR_W-1:0] fall_through;
  logic [ADDR_W-1:0] stk_dout;
  logic              stk_empty, stk_full;

  assign fall_through = ip_q + ADDR_W'(2);

  return_stack #(
    .ADDR_W      (ADDR_W),
    .STACK_DEPTH (STACK_DEPTH)
  ) u_return_stack (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .din   (fall_through),
    .dout  (stk_dout),
    .empty (stk_empty),
    .full  (stk_full)
  );

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    ip_d      = ip_q;
    temp1_d   = temp1_q;
    target_d  = target_q;
    next_ip_d = next_ip_q;
    fault_d   = fault_q;
    push      = 1'b0;
    pop       = 1'b0;

    case (state_q)
      StIdle: begin
        if (bus.start) begin
          op_d    = bus.op;
          ip_d    = bus.ip_in;
          temp1_d = bus.temp1;
          fault_d = 1'b0;
          state_d = (bus.op == OpRet) ? StPop : StMemReq;
        end
      end
      StMemReq: state_d = StMemWait;
      StMemWait: begin
        target_d = bus.mem_q;
        state_d  = StEval;
      end
      StEval: begin
        if (op_q == OpCall) begin
          // A CALL on a full stack traps without touching the stack or next ip.
          if (stk_full) begin
            fault_d = 1'b1;
          end else begin
            push      = 1'b1;
            next_ip_d = target_q;
          end
        end else if (op_q == OpGoto) begin
          next_ip_d = target_q;
        end else begin
          next_ip_d = cond_taken(op_q, longint'($signed(temp1_q))) ? target_q : fall_through;
        end
        state_d = StJmpNext;
      end
      StPop: begin
        if (stk_empty) begin
          fault_d = 1'b1;
        end else begin
          pop       = 1'b1;
          next_ip_d = stk_dout;
        end
        state_d = StJmpNext;
      end
      StJmpNext: state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      op_q      <= OpGoto;
      ip_q      <= '0;
      temp1_q   <= '0;
      target_q  <= '0;
      next_ip_q <= '0;
      fault_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      ip_q      <= ip_d;
      temp1_q   <= temp1_d;
      target_q  <= target_d;
      next_ip_q <= next_ip_d;
      fault_q   <= fault_d;
    end
  end

  assign bus.mem_rd   = (state_q == StMemReq);
  assign bus.mem_addr = (state_q == StMemReq) ? ip_q + ADDR_W'(1) : '0;
  assign bus.ip_out   = next_ip_q;
  assign bus.ip_load  = (state_q == StJmpNext) && !fault_q;
  assign bus.fault    = (state_q == StJmpNext) && fault_q;
  assign bus.done     = (state_q == StJmpNext);
  assign bus.busy     = (state_q != StIdle);
  assign bus.empty    = stk_empty;
  assign bus.full     = stk_full;

endmodule

// File: tb/tb_ctrl_transfer_unit.sv
// Directed bench for ctrl_transfer_unit with a one-cycle-latency program memory model.
module tb_ctrl_transfer_unit;
  import ct_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_errors = 0;
  logic [7:0] mem [256];

  ctrl_transfer_unit_if #(.ADDR_W(8), .DATA_W(8)) bus ();

  ctrl_transfer_unit #(
    .ADDR_W      (8),
    .DATA_W      (8),
    .STACK_DEPTH (8)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bus.mem_rd) bus.mem_q <= mem[bus.mem_addr];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Issues one instruction and samples cycle 1 and the done cycle; lat=99 on timeout.
  task automatic do_op(input ct_op_t op, input logic [7:0] ip, input logic [7:0] t,
                       output int lat, output logic [7:0] ipo, output logic ld,
                       output logic flt, output logic rd1, output logic [7:0] addr1);
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = op;
    bus.ip_in = ip;
    bus.temp1 = t;
    @(negedge clk);
    bus.start = 1'b0;
    lat   = 1;
    rd1   = bus.mem_rd;
    addr1 = bus.mem_addr;
    while (!bus.done && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    if (!bus.done) lat = 99;
    ipo = bus.ip_out;
    ld  = bus.ip_load;
    flt = bus.fault;
  endtask

  typedef struct {
    ct_op_t     op;
    logic [7:0] t;
    logic [7:0] exp;
  } vec_t;

  initial begin
    int         lat;
    logic [7:0] ipo;
    logic       ld, flt, rd1;
    logic [7:0] addr1;
    int         n_done, n_load;
    logic [7:0] done_ip;
    vec_t       vecs [10];

    for (int i = 0; i < 256; i++) mem[i] = 8'd0;
    mem[25]  = 8'd26;
    mem[21]  = 8'd33;
    mem[48]  = 8'd65;
    mem[0]   = 8'd77;
    mem[141] = 8'd200;
    for (int i = 0; i < 8; i++) mem[100 + 4*i + 1] = 8'd200;

    vecs[0] = '{OpLt, 8'hFB, 8'd33};
    vecs[1] = '{OpGt, 8'hFB, 8'd22};
    vecs[2] = '{OpLe, 8'hFB, 8'd33};
    vecs[3] = '{OpEq, 8'h00, 8'd33};
    vecs[4] = '{OpGe, 8'h00, 8'd33};
    vecs[5] = '{OpLe, 8'h00, 8'd33};
    vecs[6] = '{OpGt, 8'h00, 8'd22};
    vecs[7] = '{OpGe, 8'h07, 8'd33};
    vecs[8] = '{OpLe, 8'h07, 8'd22};
    vecs[9] = '{OpEq, 8'h07, 8'd22};

    reset     = 1'b1;
    bus.start = 1'b0;
    bus.op    = OpGoto;
    bus.ip_in = 8'd0;
    bus.temp1 = 8'd0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_ip_load", bus.ip_load, 0);
    check("rst_fault", bus.fault, 0);
    check("rst_mem_rd", bus.mem_rd, 0);
    check("rst_mem_addr", bus.mem_addr, 0);
    check("rst_ip_out", bus.ip_out, 0);
    check("rst_empty", bus.empty, 1);
    check("rst_full", bus.full, 0);

    do_op(OpGoto, 8'd24, 8'd0, lat, ipo, ld, flt, rd1, addr1);
    check("goto_mem_rd_c1", rd1, 1);
    check("goto_mem_addr", addr1, 25);
    check("goto_latency", lat, 4);
    check("goto_ip_out", ipo, 26);
    check("goto_ip_load", ld, 1);
    check("goto_fault", flt, 0);
    @(negedge clk);
    check("goto_done_single", bus.done, 0);
    check("goto_idle", bus.busy, 0);

    for (int i = 0; i < 10; i++) begin
      do_op(vecs[i].op, 8'd20, vecs[i].t, lat, ipo, ld, flt, rd1, addr1);
      check($sformatf("cond%0d_ip_out", i), ipo, vecs[i].exp);
      check($sformatf("cond%0d_ip_load", i), ld, 1);
    end

    do_op(OpCall, 8'd47, 8'd0, lat, ipo, ld, flt, rd1, addr1);
    check("call_ip_out", ipo, 65);
    check("call_latency", lat, 4);
    check("call_empty", bus.empty, 0);
    do_op(OpRet, 8'd65, 8'd0, lat, ipo, ld, flt, rd1, addr1);
    check("ret_mem_rd", rd1, 0);
    check("ret_latency", lat, 2);
    check("ret_ip_out", ipo, 49);
    check("ret_ip_load", ld, 1);
    check("ret_empty", bus.empty, 1);

    do_op(OpRet, 8'd10, 8'd0, lat, ipo, ld, flt, rd1, addr1);
    check("underflow_latency", lat, 2);
    check("underflow_fault", flt, 1);
    check("underflow_ip_load", ld, 0);
    check("underflow_empty", bus.empty, 1);
    @(negedge clk);
    check("underflow_fault_pulse", bus.fault, 0);

    for (int i = 0; i < 8; i++) begin
      do_op(OpCall, 8'(100 + 4*i), 8'd0, lat, ipo, ld, flt, rd1, addr1);
    end
    check("stack_full", bus.full, 1);
    do_op(OpCall, 8'd140, 8'd0, lat, ipo, ld, flt, rd1, addr1);
    check("overflow_latency", lat, 4);
    check("overflow_fault", flt, 1);
    check("overflow_ip_load", ld, 0);
    check("overflow_still_full", bus.full, 1);
    do_op(OpRet, 8'd200, 8'd0, lat, ipo, ld, flt, rd1, addr1);
    check("after_overflow_ret_ip", ipo, 130);
    check("after_overflow_ret_fault", flt, 0);
    check("after_overflow_not_full", bus.full, 0);

    do_op(OpGoto, 8'd255, 8'd0, lat, ipo, ld, flt, rd1, addr1);
    check("wrap_mem_addr", addr1, 0);
    check("wrap_goto_ip_out", ipo, 77);
    do_op(OpEq, 8'd255, 8'd5, lat, ipo, ld, flt, rd1, addr1);
    check("wrap_fall_through", ipo, 1);

    // Second start lands in MEM_WAIT and must be ignored.
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = OpGoto;
    bus.ip_in = 8'd24;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = OpRet;
    @(negedge clk);
    bus.start = 1'b0;
    n_done  = 0;
    done_ip = 8'd0;
    repeat (8) begin
      if (bus.done) begin
        n_done++;
        done_ip = bus.ip_out;
      end
      @(negedge clk);
    end
    check("restart_done_count", n_done, 1);
    check("restart_ip_out", done_ip, 26);

    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("pre_call_empty", bus.empty, 1);

    bus.start = 1'b1;
    bus.op    = OpCall;
    bus.ip_in = 8'd47;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort_busy", bus.busy, 0);
    check("abort_empty", bus.empty, 1);
    n_load = 0;
    repeat (6) begin
      if (bus.ip_load) n_load++;
      @(negedge clk);
    end
    check("abort_no_ip_load", n_load, 0);
    check("abort_empty_later", bus.empty, 1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/ctrl_transfer_unit.md
Name: ctrl_transfer_unit

Overview:
- Multi-cycle sequencer for all control-transfer instructions in the processor: GOTO, IF_LT, IF_GT, IF_EQ, IF_GE, IF_LE, CALL and RET.
- The main control FSM hands it the current opcode, ip and temp1. The block then:
  - fetches the branch target operand from program memory,
  - evaluates the condition,
  - manages the internal return-address stack,
  - returns the next ip with a one-cycle load strobe.
- It replaces ad-hoc jump states in the main FSM and owns the stack empty/full flags.

Parameters:
- ADDR_W, 8, width of ip, target and stack entries.
- DATA_W, 8, width of temp1.
- STACK_DEPTH, 8, number of return-address entries; must be a power of two, ≥2.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request from the main FSM; sampled only in IDLE.
- op  in  3  ct_op_t: 0 GOTO, 1 LT, 2 GT, 3 EQ, 4 GE, 5 LE, 6 CALL, 7 RET.
- ip_in  in  ADDR_W  address of the opcode byte of the current instruction.
- temp1  in  DATA_W  signed condition operand; sampled on the start cycle.
- mem_rd  out  1  program-memory read strobe.
- mem_addr  out  ADDR_W  program-memory read address.
- mem_q  in  ADDR_W  read data; valid exactly one cycle after mem_rd.
- ip_out  out  ADDR_W  next ip; valid while ip_load=1.
- ip_load  out  1  one-cycle pulse telling the main FSM to load ip_out.
- busy  out  1  high in every state except IDLE.
- fault  out  1  one-cycle pulse on stack overflow/underflow; coincides with done.
- done  out  1  one-cycle completion pulse.
- empty  out  1  return stack holds 0 entries.
- full  out  1  return stack holds STACK_DEPTH entries.

Behaviour:
- Reset values:
  - FSM in IDLE; stack pointer 0.
  - mem_rd=0, mem_addr=0, ip_out=0, ip_load=0, busy=0, fault=0, done=0.
  - empty=1, full=0.
- A reset asserted mid-operation aborts the instruction: no ip_load, and the stack is cleared.
- Instruction format: opcode at ip_in, 8-bit absolute target at ip_in+1.
- Fall-through address: ip_in+2, computed mod 2^ADDR_W (255+2 → 1). Target fetch address ip_in+1 also wraps (255 → 0).
- On start, op, ip_in and temp1 are latched. A start asserted while busy is ignored.
- FSM states and transitions:
  - IDLE: on start, op=RET → POP; any other op → MEM_REQ.
  - MEM_REQ: mem_rd=1, mem_addr=ip_in+1 → MEM_WAIT.
  - MEM_WAIT: capture mem_q as target → EVAL.
  - EVAL: compute next ip (see rules below) → JMP_NEXT.
  - POP: on empty, set fault → JMP_NEXT; otherwise pop → JMP_NEXT.
  - JMP_NEXT: ip_load=1 (unless fault), done=1 → IDLE.
- EVAL rules:
  - GOTO: next = target.
  - Conditional ops compare signed temp1 with 0. Taken → next = target; not taken → next = ip_in+2. Taken conditions: LT t<0, GT t>0, EQ t==0, GE t>=0, LE t<=0.
  - CALL: if full, set fault and do not push. Otherwise push ip_in+2 and next = target.
- Latency, start to done: 4 cycles for GOTO/IF/CALL, 2 cycles for RET. busy is high from the cycle after start through the JMP_NEXT cycle.
- Fault behaviour:
  - fault=1 and done=1 in JMP_NEXT, with ip_load=0.
  - Stack contents and pointer are unchanged.
  - The main FSM handles the trap.
- Stack push/pop occurs only on a successful CALL (in EVAL) or RET (in POP). Push and pop never happen in the same cycle.
- empty and full are registered and derived from the pointer.
- Arithmetic: temp1 is treated as two's complement (-128..127); ip arithmetic is unsigned with wrap.

Decomposition:
- Shared package ct_pkg:
  - ct_op_t enum (3-bit, encoding above),
  - ct_state_t enum (IDLE, MEM_REQ, MEM_WAIT, EVAL, POP, JMP_NEXT),
  - the function cond_taken(op, temp1).
- Sub-module return_stack (clk, reset, push, pop, din, dout, empty, full), parameterised by ADDR_W and STACK_DEPTH. It is a register-array LIFO with a pointer of width log2(STACK_DEPTH)+1.

Test Plan:
- GOTO: ip_in=24, mem[25]=26 → mem_rd at cycle 1 with mem_addr=25; ip_load with ip_out=26 and done at cycle 4.
- Conditional ops, ip_in=20, target 33:
  - temp1=-5: LT taken → 33; GT not taken → 22; LE taken → 33.
  - temp1=0: EQ taken → 33; GE taken → 33; LE taken → 33; GT → 22.
  - temp1=+7: GE taken → 33; LE → 22; EQ → 22.
- CALL/RET: CALL at ip_in=47 with target 65 → ip_out=65, empty deasserts. A following RET → ip_out=49 two cycles after start, and empty=1 again.
- Overflow/underflow:
  - 8 CALLs → full=1; a 9th CALL → fault=1, done=1, ip_load=0, stack unchanged.
  - RET on an empty stack → fault pulse, no ip_load.
- Wrap-around: GOTO with ip_in=255 → mem_addr=0. IF_EQ not taken with ip_in=255 → ip_out=1.
- Robustness:
  - start re-asserted during MEM_WAIT → ignored, a single done.
  - reset asserted in EVAL after a pending CALL → IDLE, empty=1, no ip_load.
